lcd_screen_refresh: RTL
=======================

Name: lcd_screen_refresh

Overview:
- Client-side stage directly upstream of the LCD driver; drives its rq/ack/row/column/character interface.
- Holds a 2x16 shadow character buffer written by the host at any rate, one cell per cycle.
- Tracks changed ("dirty") cells and streams them one at a time to the driver, so the host never waits on the slow LCD timing.

Parameters:
- LCD_COLS, 16, visible columns per row (power of two, 2..32).
- COL_W, 4, log2(LCD_COLS).
- BLANK_CHAR, 8'h20, fill character used on reset and on clear.

Ports:
- clk_i  in  1  clock, 50 MHz.
- reset_i  in  1  synchronous reset, active high.
- wr_i  in  1  host write strobe, one cell per cycle.
- wr_row_i  in  1  host write row.
- wr_col_i  in  COL_W  host write column.
- wr_char_i  in  8  host write character.
- clr_i  in  1  clear screen: fill with BLANK_CHAR and mark all cells dirty.
- busy_o  out  1  high while any cell is dirty or a transfer is outstanding.
- rq_o  out  1  request to the LCD driver.
- ack_i  in  1  driver acknowledge, one-cycle pulse.
- lcd_row_o  out  1  row of the current request.
- lcd_column_o  out  6  column of the current request, zero-extended from COL_W.
- lcd_character_o  out  8  character of the current request.

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active high on reset_i. All state updates on the rising edge.
- Reset values:
  - rq_o=0, lcd_row_o=0, lcd_column_o=0, lcd_character_o=8'h00.
  - All buffer cells set to BLANK_CHAR; all 2*LCD_COLS dirty bits set.
  - Scan pointer=0; state=IDLE.
  - busy_o=1 from the first cycle after reset, so the screen is blanked after power-up. The driver withholds ack until its own power-up completes.
- Cell index: idx = {row, col}, 0..2*LCD_COLS-1. The scan pointer wraps from the last index to 0.
- Host write (wr_i): buffer[idx] <= wr_char_i; dirty[idx] <= 1, effective the next cycle.
- clr_i:
  - All cells <= BLANK_CHAR; all dirty <= 1.
  - If wr_i is asserted in the same cycle, clr_i wins and wr_i is ignored.
- FSM states IDLE, SCAN, REQ, GAP:
  - IDLE: if any dirty bit is set -> SCAN.
  - SCAN: test dirty[ptr].
    - If set: latch row/column/character from buffer[ptr] into the outputs, clear dirty[ptr], go to REQ.
    - Otherwise ptr <= ptr+1.
    - If no dirty bit is set -> IDLE.
    - One cell is tested per cycle; worst-case search is 2*LCD_COLS cycles.
  - REQ: rq_o=1 with outputs held stable. On ack_i=1: rq_o <= 0, ptr <= ptr+1, go to GAP.
  - GAP: one cycle with rq_o=0 (the driver sees a clean falling edge); then SCAN if any dirty bit is set, else IDLE.
- Ack rule: ack_i outside REQ is ignored.
- Handshake latency:
  - Dirty cell found in SCAN -> rq_o high on the next cycle.
  - ack -> rq_o low on the next cycle.
  - Minimum spacing between requests is 3 cycles (REQ ack, GAP, SCAN hit).
- Simultaneous events:
  - Host write to the cell being latched in the same SCAN cycle: the set wins over the clear, so the cell stays dirty. The old character is sent, then the cell is resent.
  - Host write during REQ to the in-flight cell: the outputs do not change; dirty is re-set and the cell is resent later.
  - clr_i during REQ: the in-flight transfer completes unchanged, then all cells are resent.
- busy_o = (state != IDLE) | (|dirty).
- reset_i during REQ: rq_o drops in the next cycle with no wait for ack. The driver is reset by the same signal.

Decomposition:
- Package lcd_pkg:
  - Constants LCD_ROWS=2, LCD_COLS, COL_W, BLANK_CHAR.
  - State enum {IDLE, SCAN, REQ, GAP}.
  - Cell-index typedef.
- Sub-module lcd_char_buffer: the 2*LCD_COLS x 8 register array plus the dirty vector, with write, clear, read-at-ptr and clear-dirty-at-ptr ports, and set-over-clear priority. The top level holds the FSM, pointer and output registers.

Test Plan:
- Reset, driver acks 2 cycles after each rq -> exactly 32 requests, in order (0,0)..(0,15),(1,0)..(1,15), all characters 8'h20; busy_o falls after the last GAP.
- Idle screen; write 'A' (8'h41) to (1,5) -> one request row=1, column=6'd5, char 8'h41; rq_o held until ack; no other requests.
- Writes to (0,3)='x' then (0,3)='y' on consecutive cycles before the scan reaches it -> a single request for (0,3) with 'y'.
- While (0,7) is in REQ with ack delayed 20 cycles, write 'Q' to (0,7) -> outputs stay on the old character until ack, then a second request sends (0,7)='Q'.
- clr_i and wr_i ('Z' to (0,0)) in the same cycle -> the buffer is all 8'h20 and 32 requests follow; no 'Z' is sent.
- reset_i asserted mid-REQ -> rq_o=0 the next cycle, and the 32-cell blank sweep restarts from (0,0).

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the LCD screen refresh stage.
//   LCD_ROWS/LCD_COLS/COL_W : screen geometry (cell index = {row, col})
//   BLANK_CHAR              : fill character for reset and clear
//   state_e                 : refresh FSM states
//   cell_idx_t              : flat cell index for the default geometry
package lcd_pkg;
    localparam int          LCD_ROWS   = 2;
    localparam int          LCD_COLS   = 16;
    localparam int          COL_W      = 4;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        REQ  = 2'd2,
        GAP  = 2'd3
    } state_e;

    typedef logic [COL_W:0] cell_idx_t;
endpackage

// File: rtl/lcd_char_buffer.sv
// lcd_char_buffer: 2 x LCD_COLS shadow character array plus per-cell dirty bits.
//   clk_i, reset_i : clock, synchronous active-high reset (fills blank, all dirty)
//   wr, wr_idx, wr_char : host cell write, marks the cell dirty
//   clr            : fill every cell with BLANK_CHAR and mark all dirty (beats wr)
//   rd_idx         : scan pointer; rd_char/rd_dirty show that cell
//   clr_dirty      : clear the dirty bit at rd_idx (a same-cycle set wins)
//   any_dirty      : OR of all dirty bits
module lcd_char_buffer #(
    parameter int         LCD_COLS   = 16,
    parameter int         COL_W      = 4,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr,
    input  logic [COL_W:0]   wr_idx,
    input  logic [7:0]       wr_char,
    input  logic             clr,
    input  logic [COL_W:0]   rd_idx,
    input  logic             clr_dirty,
    output logic [7:0]       rd_char,
    output logic             rd_dirty,
    output logic             any_dirty
);
    localparam int CELLS = 2 * LCD_COLS;
    localparam int IDX_W = COL_W + 1;

    logic [7:0]       cells [CELLS];
    logic [CELLS-1:0] dirty;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= BLANK_CHAR;
            dirty <= '1;
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                if (clr)
                    cells[i] <= BLANK_CHAR;
                else if (wr && wr_idx == IDX_W'(i))
                    cells[i] <= wr_char;
                // Set beats clear so a write racing the scan latch is resent.
                dirty[i] <= clr
                          | (wr && wr_idx == IDX_W'(i))
                          | (dirty[i] & ~(clr_dirty && rd_idx == IDX_W'(i)));
            end
        end
    end

    assign rd_char   = cells[rd_idx];
    assign rd_dirty  = dirty[rd_idx];
    assign any_dirty = |dirty;
endmodule

// File: rtl/lcd_screen_refresh.sv
// lcd_screen_refresh: streams dirty shadow-buffer cells to the LCD driver.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   wr_i, wr_row_i, wr_col_i, wr_char_i : host cell write (one per cycle)
//   clr_i            : blank screen and resend every cell
//   busy_o           : dirty cells pending or a transfer in progress
//   rq_o, ack_i      : request / one-cycle acknowledge with the driver
//   lcd_row_o, lcd_column_o, lcd_character_o : registered request payload
module lcd_screen_refresh #(
    parameter int         LCD_COLS   = 16,
    parameter int         COL_W      = 4,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_i,
    input  logic             wr_row_i,
    input  logic [COL_W-1:0] wr_col_i,
    input  logic [7:0]       wr_char_i,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             rq_o,
    input  logic             ack_i,
    output logic             lcd_row_o,
    output logic [5:0]       lcd_column_o,
    output logic [7:0]       lcd_character_o
);
    import lcd_pkg::*;

    state_e         state;
    logic [COL_W:0] ptr;
    logic [7:0]     rd_char;
    logic           rd_dirty;
    logic           any_dirty;
    logic           clr_dirty;

    // A dirty hit in SCAN is consumed as it is latched into the outputs.
    assign clr_dirty = (state == SCAN) && rd_dirty;

    lcd_char_buffer #(
        .LCD_COLS   (LCD_COLS),
        .COL_W      (COL_W),
        .BLANK_CHAR (BLANK_CHAR)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr        (wr_i),
        .wr_idx    ({wr_row_i, wr_col_i}),
        .wr_char   (wr_char_i),
        .clr       (clr_i),
        .rd_idx    (ptr),
        .clr_dirty (clr_dirty),
        .rd_char   (rd_char),
        .rd_dirty  (rd_dirty),
        .any_dirty (any_dirty)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state           <= IDLE;
            ptr             <= '0;
            rq_o            <= 1'b0;
            lcd_row_o       <= 1'b0;
            lcd_column_o    <= 6'd0;
            lcd_character_o <= 8'h00;
        end else begin
            case (state)
                IDLE: if (any_dirty) state <= SCAN;
                SCAN: begin
                    if (rd_dirty) begin
                        lcd_row_o       <= ptr[COL_W];
                        lcd_column_o    <= 6'(ptr[COL_W-1:0]);
                        lcd_character_o <= rd_char;
                        rq_o            <= 1'b1;
                        state           <= REQ;
                    end else if (!any_dirty) begin
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                REQ: begin
                    // Payload is frozen here; later writes only re-mark dirty.
                    if (ack_i) begin
                        rq_o  <= 1'b0;
                        ptr   <= ptr + 1'b1;
                        state <= GAP;
                    end
                end
                GAP: state <= any_dirty ? SCAN : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE) | any_dirty;
endmodule
